// File: rtl/id_tracker_multi_if.sv
// id_tracker_multi_if
// Bundles the allocate, retire and flush signals of the multi-port tag tracker.
//   master : dispatch/retire side. Drives new_tag_consume, old_tag_done,
//            old_tag and flush.
//   slave  : the tracker. Drives new_tag_ready, new_tag and free_count,
//            plus double_free_err when the check is built in.
// Macro ID_TRACKER_MULTI_DOUBLE_FREE_CHECK_EN adds the double_free_err signal.
interface id_tracker_multi_if #(
  parameter int TAG_COUNT   = 8,
  parameter int TAG_WIDTH   = $clog2(TAG_COUNT),
  parameter int ALLOC_PORTS = 2,
  parameter int FREE_PORTS  = 2
);
  localparam int CNT_W = $clog2(TAG_COUNT + 1);

  logic [ALLOC_PORTS-1:0]                new_tag_consume;
  logic [ALLOC_PORTS-1:0]                new_tag_ready;
  logic [ALLOC_PORTS-1:0][TAG_WIDTH-1:0] new_tag;
  logic [FREE_PORTS-1:0]                 old_tag_done;
  logic [FREE_PORTS-1:0][TAG_WIDTH-1:0]  old_tag;
  logic                                  flush;
  logic [CNT_W-1:0]                      free_count;
`ifdef ID_TRACKER_MULTI_DOUBLE_FREE_CHECK_EN
  logic                                  double_free_err;
`endif

  modport master (
    output new_tag_consume, old_tag_done, old_tag, flush,
`ifdef ID_TRACKER_MULTI_DOUBLE_FREE_CHECK_EN
    input  double_free_err,
`endif
    input  new_tag_ready, new_tag, free_count
  );

  modport slave (
    input  new_tag_consume, old_tag_done, old_tag, flush,
`ifdef ID_TRACKER_MULTI_DOUBLE_FREE_CHECK_EN
    output double_free_err,
`endif
    output new_tag_ready, new_tag, free_count
  );
endinterface

// File: rtl/id_tracker_multi.sv
// id_tracker_multi
// Multi-port tag allocator/retirer. Keeps a free mask (bit set = tag free).
// Each cycle it offers the lowest free tags on the allocation ports and
// accepts retired tags on the free ports. It also supports a one-cycle flush
// that returns every tag to the pool.
// Ports:
//   CLK : clock; all state updates on the rising edge
//   RST : synchronous active-high reset; the pool becomes entirely free
//   bus : id_tracker_multi_if.slave. Carries consume/ready/new_tag per alloc
//         port, done/old_tag per free port, flush and free_count.
// Macro ID_TRACKER_MULTI_DOUBLE_FREE_CHECK_EN builds the sticky
// double_free_err flag. Without it the flag and its logic are absent.
module id_tracker_multi #(
  parameter int TAG_COUNT   = 8,
  parameter int TAG_WIDTH   = $clog2(TAG_COUNT),
  parameter int ALLOC_PORTS = 2,
  parameter int FREE_PORTS  = 2
) (
  input logic              CLK,
  input logic              RST,
  id_tracker_multi_if.slave bus
);
  localparam int CNT_W = $clog2(TAG_COUNT + 1);

  logic [TAG_COUNT-1:0]                  free_mask_reg;
  logic [TAG_COUNT-1:0]                  free_mask_next;
  logic [TAG_COUNT-1:0]                  alloc_mask;
  logic [TAG_COUNT-1:0]                  retire_mask;
  logic [CNT_W-1:0]                      free_count;
  logic [ALLOC_PORTS-1:0][TAG_WIDTH-1:0] offer_tag;
  logic [ALLOC_PORTS-1:0]                offer_ready;
  logic [FREE_PORTS-1:0]                 retire_valid;

  // One pass over the mask both counts free tags and picks the i-th lowest
  // free tag for port i. Ports beyond the free count keep the default 0.
  always_comb begin : offer_scan
    logic [CNT_W-1:0] seen;
    seen      = '0;
    offer_tag = '0;
    for (int b = 0; b < TAG_COUNT; b++) begin
      if (free_mask_reg[b]) begin
        for (int i = 0; i < ALLOC_PORTS; i++) begin
          if (seen == CNT_W'(i)) offer_tag[i] = TAG_WIDTH'(b);
        end
        seen = seen + CNT_W'(1);
      end
    end
    free_count = seen;
  end

  // Port i is ready when more than i tags are free. This keeps ready a
  // thermometer vector.
  generate
    for (genvar gi = 0; gi < ALLOC_PORTS; gi++) begin : g_ready
      assign offer_ready[gi] = (free_count > CNT_W'(gi));
    end
    // Out-of-range tags (only possible for non power-of-two pools) are dropped.
    for (genvar gi = 0; gi < FREE_PORTS; gi++) begin : g_retire_valid
      assign retire_valid[gi] = bus.old_tag_done[gi] &&
                                (int'(bus.old_tag[gi]) < TAG_COUNT);
    end
  endgenerate

  always_comb begin
    alloc_mask = '0;
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      if (bus.new_tag_consume[i] && offer_ready[i]) alloc_mask[offer_tag[i]] = 1'b1;
    end
  end

  always_comb begin
    retire_mask = '0;
    for (int j = 0; j < FREE_PORTS; j++) begin
      if (retire_valid[j]) retire_mask[bus.old_tag[j]] = 1'b1;
    end
  end

  // Retire is ORed in after the allocate clear, so it wins on a shared tag.
  always_comb begin
    if (bus.flush) free_mask_next = '1;
    else           free_mask_next = (free_mask_reg & ~alloc_mask) | retire_mask;
  end

  always_ff @(posedge CLK) begin
    if (RST) free_mask_reg <= '1;
    else     free_mask_reg <= free_mask_next;
  end

  assign bus.new_tag_ready = offer_ready;
  assign bus.new_tag       = offer_tag;
  assign bus.free_count    = free_count;

`ifdef ID_TRACKER_MULTI_DOUBLE_FREE_CHECK_EN
  logic double_free_hit;
  logic double_free_err_reg;

  // A double free is one of two cases:
  //   - a retire of a tag that is already free;
  //   - two ports retiring the same tag in one cycle.
  always_comb begin
    double_free_hit = 1'b0;
    for (int j = 0; j < FREE_PORTS; j++) begin
      if (retire_valid[j]) begin
        if (free_mask_reg[bus.old_tag[j]]) double_free_hit = 1'b1;
        for (int k = j + 1; k < FREE_PORTS; k++) begin
          if (retire_valid[k] && (bus.old_tag[k] == bus.old_tag[j]))
            double_free_hit = 1'b1;
        end
      end
    end
  end

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge CLK) begin
    if (RST)                  double_free_err_reg <= 1'b0;
    else if (double_free_hit) double_free_err_reg <= 1'b1;
  end

  assign bus.double_free_err = double_free_err_reg;
`endif
endmodule

// File: tb/tb_id_tracker_multi.sv
// tb_id_tracker_multi
// Directed bench for id_tracker_multi (TAG_COUNT=8, ALLOC_PORTS=2, FREE_PORTS=2).
// The driver pushes hand-computed expectations tagged with the cycle they
// apply to. A negedge monitor pops and compares them.
// The double_free_err expectations apply when
// ID_TRACKER_MULTI_DOUBLE_FREE_CHECK_EN is defined.
module tb_id_tracker_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle_count = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle_count <= cycle_count + 1;

  id_tracker_multi_if #(.TAG_COUNT(8), .ALLOC_PORTS(2), .FREE_PORTS(2)) bus ();

  id_tracker_multi #(.TAG_COUNT(8), .ALLOC_PORTS(2), .FREE_PORTS(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    int         fc;
    logic [1:0] rdy;
    int         t0;
    int         t1;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cycle_count);
    end
  endtask

  // Inputs change 1 time unit after the rising edge. The expectation
  // describes the state visible after the next rising edge.
  task automatic step(input logic r, input logic fl, input logic [1:0] cons,
                      input logic [1:0] done, input int ot0, input int ot1,
                      input int fc, input logic [1:0] rdy, input int t0,
                      input int t1, input logic err);
    exp_t e;
    rst                 = r;
    bus.flush           = fl;
    bus.new_tag_consume = cons;
    bus.old_tag_done    = done;
    bus.old_tag[0]      = 3'(ot0);
    bus.old_tag[1]      = 3'(ot1);
    e.cyc = cycle_count + 1;
    e.fc  = fc;
    e.rdy = rdy;
    e.t0  = t0;
    e.t1  = t1;
    e.err = err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cycle_count) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("cycle_align", cycle_count, e.cyc);
      $display("cyc %0d: free_count=%0d ready=%b tags=(%0d,%0d)", cycle_count,
               bus.free_count, bus.new_tag_ready, bus.new_tag[0], bus.new_tag[1]);
      chk("free_count", 32'(bus.free_count), e.fc);
      chk("new_tag_ready", 32'(bus.new_tag_ready), 32'(e.rdy));
      chk("new_tag0", 32'(bus.new_tag[0]), e.t0);
      chk("new_tag1", 32'(bus.new_tag[1]), e.t1);
`ifdef ID_TRACKER_MULTI_DOUBLE_FREE_CHECK_EN
      chk("double_free_err", 32'(bus.double_free_err), 32'(e.err));
`endif
    end
  end

  initial begin
    bus.flush = 1'b0;
    bus.new_tag_consume = '0;
    bus.old_tag_done = '0;
    bus.old_tag = '0;
    //   rst fl cons   done  ot0 ot1  fc rdy   t0 t1 err
    step(1, 0, 2'b00, 2'b00, 0, 0,   8, 2'b11, 0, 1, 0);  // reset state
    step(0, 0, 2'b11, 2'b00, 0, 0,   6, 2'b11, 2, 3, 0);
    step(0, 0, 2'b11, 2'b00, 0, 0,   4, 2'b11, 4, 5, 0);
    step(0, 0, 2'b11, 2'b00, 0, 0,   2, 2'b11, 6, 7, 0);
    step(0, 0, 2'b11, 2'b00, 0, 0,   0, 2'b00, 0, 0, 0);  // pool exhausted
    step(0, 0, 2'b11, 2'b00, 0, 0,   0, 2'b00, 0, 0, 0);  // consume while empty ignored
    step(0, 0, 2'b00, 2'b11, 3, 5,   2, 2'b11, 3, 5, 0);  // retire 3,5 from full pool
    step(0, 0, 2'b01, 2'b01, 7, 0,   2, 2'b11, 5, 7, 0);  // take 3, retire 7
    step(0, 0, 2'b01, 2'b00, 0, 0,   1, 2'b01, 7, 0, 0);  // take 5: only 7 free
    step(0, 0, 2'b10, 2'b00, 0, 0,   1, 2'b01, 7, 0, 0);  // consume on non-ready port ignored
    step(0, 0, 2'b01, 2'b00, 0, 0,   0, 2'b00, 0, 0, 0);  // take 7
    step(0, 0, 2'b00, 2'b01, 7, 0,   1, 2'b01, 7, 0, 0);  // retire restores offer
    step(1, 0, 2'b11, 2'b00, 0, 0,   8, 2'b11, 0, 1, 0);  // mid-run reset
    step(0, 0, 2'b11, 2'b00, 0, 0,   6, 2'b11, 2, 3, 0);  // allocate 0,1
    step(0, 0, 2'b01, 2'b01, 0, 0,   6, 2'b11, 0, 3, 0);  // retire 0 while taking 2
    step(0, 0, 2'b11, 2'b00, 0, 0,   4, 2'b11, 4, 5, 0);  // take 0,3
    step(0, 1, 2'b11, 2'b01, 2, 0,   8, 2'b11, 0, 1, 0);  // flush overrides all
    step(0, 0, 2'b11, 2'b00, 0, 0,   6, 2'b11, 2, 3, 0);
    step(0, 0, 2'b00, 2'b01, 4, 0,   6, 2'b11, 2, 3, 1);  // double free of tag 4
    step(0, 1, 2'b00, 2'b00, 0, 0,   8, 2'b11, 0, 1, 1);  // flush keeps error
    step(0, 0, 2'b10, 2'b00, 0, 0,   7, 2'b11, 0, 2, 1);  // only port 1 consumes
    step(1, 0, 2'b00, 2'b00, 0, 0,   8, 2'b11, 0, 1, 0);  // reset clears error
    step(0, 0, 2'b01, 2'b00, 0, 0,   7, 2'b11, 1, 2, 0);  // take 0
    step(0, 0, 2'b00, 2'b11, 0, 0,   8, 2'b11, 0, 1, 1);  // same tag on both free ports
    step(0, 0, 2'b00, 2'b00, 0, 0,   8, 2'b11, 0, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
